// File: rtl/hsst_rst_pkg.sv
// Shared HSST reset-sequencing definitions: TX init FSM state encodings,
// default counter values and a counter width helper.
package hsst_rst_pkg;

  typedef enum logic [2:0] {
    TX_IDLE     = 3'd0,
    TX_PLL_WAIT = 3'd1,
    TX_PMA_RST  = 3'd2,
    TX_PCS_RST  = 3'd3,
    TX_DONE     = 3'd4
  } tx_init_state_e;

  localparam int PLL_DEB_CNTR_WIDTH_DEF = 12;
  localparam int PLL_DEB_CNTR_VALUE_DEF = 2048;
  localparam int PMA_RST_CNTR_VALUE_DEF = 64;
  localparam int PCS_RST_CNTR_VALUE_DEF = 32;

  // Bits needed for a down-counter loaded with (max(a,b) - 1).
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hsstl_rst4mcrsw_tx_rst_initfsm_v1_0.sv
// TX init sequencing FSM with the shared PMA/PCS hold down-counter.
// Optional feature: HSSTL_TX_PLL_LOSS_RERST_EN re-enters PLL_WAIT on PLL loss.
//
// state    | meaning
// IDLE     | lane not powered, both resets asserted
// PLL_WAIT | powered, waiting for debounced PLL ready
// PMA_RST  | PMA held in reset for PMA_RST_CNTR_VALUE cycles
// PCS_RST  | PMA released, PCS held for PCS_RST_CNTR_VALUE cycles
// DONE     | both resets released, init_done high
module hsstl_rst4mcrsw_tx_rst_initfsm_v1_0
  import hsst_rst_pkg::*;
#(
  parameter int PMA_RST_CNTR_VALUE = PMA_RST_CNTR_VALUE_DEF,
  parameter int PCS_RST_CNTR_VALUE = PCS_RST_CNTR_VALUE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lane_powerup,
  input  logic       pll_ready_deb,
  output logic [2:0] state,
  output logic       pma_rstn,
  output logic       pcs_rstn,
  output logic       init_done
);

  localparam int CNT_W = cnt_width(PMA_RST_CNTR_VALUE, PCS_RST_CNTR_VALUE);
  localparam logic [CNT_W-1:0] PMA_LOAD = CNT_W'(PMA_RST_CNTR_VALUE - 1);
  localparam logic [CNT_W-1:0] PCS_LOAD = CNT_W'(PCS_RST_CNTR_VALUE - 1);

  tx_init_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pma_rstn_q, pma_rstn_d;
  logic             pcs_rstn_q, pcs_rstn_d;
  logic             init_done_q, init_done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    // Powerup loss outranks every other transition, including terminal count.
    if (!lane_powerup) begin
      state_d = TX_IDLE;
      cnt_d   = '0;
    end
`ifdef HSSTL_TX_PLL_LOSS_RERST_EN
    else if (!pll_ready_deb && (state_q == TX_PMA_RST || state_q == TX_PCS_RST ||
                                state_q == TX_DONE)) begin
      state_d = TX_PLL_WAIT;
      cnt_d   = '0;
    end
`endif
    else begin
      unique case (state_q)
        TX_IDLE: begin
          state_d = TX_PLL_WAIT;
          cnt_d   = '0;
        end
        TX_PLL_WAIT: begin
          if (pll_ready_deb) begin
            state_d = TX_PMA_RST;
            cnt_d   = PMA_LOAD;
          end
        end
        TX_PMA_RST: begin
          if (cnt_q == '0) begin
            state_d = TX_PCS_RST;
            cnt_d   = PCS_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        TX_PCS_RST: begin
          if (cnt_q == '0) begin
            state_d = TX_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        TX_DONE: ;
        default: begin
          state_d = TX_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    // Outputs follow the next state so they change on the same edge as the state.
    pma_rstn_d  = (state_d == TX_PCS_RST) || (state_d == TX_DONE);
    pcs_rstn_d  = (state_d == TX_DONE);
    init_done_d = (state_d == TX_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TX_IDLE;
      cnt_q       <= '0;
      pma_rstn_q  <= 1'b0;
      pcs_rstn_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pma_rstn_q  <= pma_rstn_d;
      pcs_rstn_q  <= pcs_rstn_d;
      init_done_q <= init_done_d;
    end
  end

  assign state     = state_q;
  assign pma_rstn  = pma_rstn_q;
  assign pcs_rstn  = pcs_rstn_q;
  assign init_done = init_done_q;

endmodule

// File: rtl/hsstl_rst4mcrsw_tx_init_v1_0.sv
// HSST TX lane init: PLL-ready synchronizer and debounce feeding the init FSM.
// Optional feature: HSSTL_TX_PLL_LOSS_RERST_EN (handled inside the FSM sub-module).
module hsstl_rst4mcrsw_tx_init_v1_0
  import hsst_rst_pkg::*;
#(
  parameter int PLL_DEB_CNTR_WIDTH = PLL_DEB_CNTR_WIDTH_DEF,
  parameter int PLL_DEB_CNTR_VALUE = PLL_DEB_CNTR_VALUE_DEF,
  parameter int PMA_RST_CNTR_VALUE = PMA_RST_CNTR_VALUE_DEF,
  parameter int PCS_RST_CNTR_VALUE = PCS_RST_CNTR_VALUE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txlane_soft_rst_n,
  input  logic       P_PLL_READY,
  input  logic       P_TX_LANE_POWERUP,
  output logic       s_PLL_READY,
  output logic       s_PLL_READY_deb,
  output logic [2:0] tx_init_fsm,
  output logic       P_TX_PMA_RSTN,
  output logic       P_PCS_TX_RSTN,
  output logic       init_done
);

  localparam logic [PLL_DEB_CNTR_WIDTH-1:0] DEB_LOAD =
    PLL_DEB_CNTR_WIDTH'(PLL_DEB_CNTR_VALUE - 1);

  logic                          rst_all;
  logic [1:0]                    sync_q, sync_d;
  logic [PLL_DEB_CNTR_WIDTH-1:0] deb_cnt_q, deb_cnt_d;
  logic                          deb_q, deb_d;

  assign rst_all = rst | ~txlane_soft_rst_n;

  // Down-counter reloads whenever the synchronized level is low, so only an
  // unbroken run of highs can reach terminal count.
  always_comb begin
    sync_d    = {sync_q[0], P_PLL_READY};
    deb_cnt_d = deb_cnt_q;
    deb_d     = deb_q;
    if (!sync_q[1]) begin
      deb_cnt_d = DEB_LOAD;
      deb_d     = 1'b0;
    end else if (deb_cnt_q == '0) begin
      deb_d = 1'b1;
    end else begin
      deb_cnt_d = deb_cnt_q - PLL_DEB_CNTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_all) begin
      sync_q    <= '0;
      deb_cnt_q <= '0;
      deb_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      deb_cnt_q <= deb_cnt_d;
      deb_q     <= deb_d;
    end
  end

  assign s_PLL_READY     = sync_q[1];
  assign s_PLL_READY_deb = deb_q;

  hsstl_rst4mcrsw_tx_rst_initfsm_v1_0 #(
    .PMA_RST_CNTR_VALUE (PMA_RST_CNTR_VALUE),
    .PCS_RST_CNTR_VALUE (PCS_RST_CNTR_VALUE)
  ) u_initfsm (
    .clk           (clk),
    .rst           (rst_all),
    .lane_powerup  (P_TX_LANE_POWERUP),
    .pll_ready_deb (deb_q),
    .state         (tx_init_fsm),
    .pma_rstn      (P_TX_PMA_RSTN),
    .pcs_rstn      (P_PCS_TX_RSTN),
    .init_done     (init_done)
  );

endmodule
